// File: rtl/bcd_disp_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_disp_scan_if
//  Description : Bundle between the BCD clock core and the display scanner.
//                The master drives the time/control fields and the slave
//                (scanner) drives the 7-segment outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_disp_scan_if;
    logic [7:0] bcd_hour;
    logic [7:0] bcd_min;
    logic [7:0] bcd_sec;
    logic [2:0] blink_sel;
    logic       colon_on;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    modport master (
        output bcd_hour, bcd_min, bcd_sec, blink_sel, colon_on,
        input  seg, dp, an
    );

    modport slave (
        input  bcd_hour, bcd_min, bcd_sec, blink_sel, colon_on,
        output seg, dp, an
    );
endinterface
`default_nettype wire

// File: rtl/bcd_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_disp_scan
//  Description : 6-digit multiplexed 7-segment scanner for HH:MM:SS BCD time.
//                Inputs are snapshotted once per frame so a display frame is
//                never torn; supports hour leading-zero blanking, invalid
//                nibble dash, per-field blinking and colon decimal points.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_disp_scan #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLINK_DIV     = 25000000,
    parameter bit SEG_ACT_LOW   = 1'b1,
    parameter bit AN_ACT_LOW    = 1'b1,
    parameter bit HOUR_LZ_BLANK = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bcd_disp_scan_if.slave  bus
);

    localparam int c_scan_w  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
    localparam logic [2:0]           c_idx_last   = 3'd5;

    // Inactive output levels for the configured polarities
    localparam logic [6:0] c_seg_off = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic       c_dp_off  = SEG_ACT_LOW;
    localparam logic [5:0] c_an_off  = AN_ACT_LOW  ? 6'h3F : 6'h00;

    logic [c_scan_w-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [2:0]           idx_q,       idx_d;
    logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_ph_q,  blink_ph_d;
    logic [7:0]           snap_hour_q, snap_hour_d;
    logic [7:0]           snap_min_q,  snap_min_d;
    logic [7:0]           snap_sec_q,  snap_sec_d;
    logic [6:0]           seg_q,       seg_d;
    logic                 dp_q,        dp_d;
    logic [5:0]           an_q,        an_d;

    logic                 w_scan_tick;
    logic                 w_frame_end;
    logic                 w_blink_wrap;
    logic [3:0]           w_nibble;
    logic                 w_field_blink;
    logic                 w_blank;
    logic [6:0]           w_seg_on;
    logic                 w_dp_on;
    logic [5:0]           w_an_on;

    // Active-low decode table, {g..a}; anything above 9 renders as a dash
    function automatic logic [6:0] seg_code_low(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code_low = 7'h40;
            4'd1:    seg_code_low = 7'h79;
            4'd2:    seg_code_low = 7'h24;
            4'd3:    seg_code_low = 7'h30;
            4'd4:    seg_code_low = 7'h19;
            4'd5:    seg_code_low = 7'h12;
            4'd6:    seg_code_low = 7'h02;
            4'd7:    seg_code_low = 7'h78;
            4'd8:    seg_code_low = 7'h00;
            4'd9:    seg_code_low = 7'h10;
            default: seg_code_low = 7'h3F;
        endcase
    endfunction

    // Digit scan counter, digit index and once-per-frame input snapshot
    always_comb begin
        w_scan_tick = (scan_cnt_q == c_scan_last);
        w_frame_end = w_scan_tick && (idx_q == c_idx_last);
        scan_cnt_d  = w_scan_tick ? '0 : scan_cnt_q + 1'b1;
        idx_d       = idx_q;
        if (w_scan_tick) begin
            idx_d = (idx_q == c_idx_last) ? 3'd0 : idx_q + 3'd1;
        end
        snap_hour_d = w_frame_end ? bus.bcd_hour : snap_hour_q;
        snap_min_d  = w_frame_end ? bus.bcd_min  : snap_min_q;
        snap_sec_d  = w_frame_end ? bus.bcd_sec  : snap_sec_q;
    end

    // Free-running blink phase, independent of the scan
    always_comb begin
        w_blink_wrap = (blink_cnt_q == c_blink_last);
        blink_cnt_d  = w_blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_ph_d   = blink_ph_q ^ w_blink_wrap;
    end

    // Select the current digit, apply blanking, then map to output polarity
    always_comb begin
        w_nibble      = 4'd0;
        w_field_blink = 1'b0;
        case (idx_q)
            3'd0: begin w_nibble = snap_sec_q[3:0];  w_field_blink = bus.blink_sel[0]; end
            3'd1: begin w_nibble = snap_sec_q[7:4];  w_field_blink = bus.blink_sel[0]; end
            3'd2: begin w_nibble = snap_min_q[3:0];  w_field_blink = bus.blink_sel[1]; end
            3'd3: begin w_nibble = snap_min_q[7:4];  w_field_blink = bus.blink_sel[1]; end
            3'd4: begin w_nibble = snap_hour_q[3:0]; w_field_blink = bus.blink_sel[2]; end
            3'd5: begin w_nibble = snap_hour_q[7:4]; w_field_blink = bus.blink_sel[2]; end
            default: begin w_nibble = 4'd0; w_field_blink = 1'b0; end
        endcase

        w_blank  = (HOUR_LZ_BLANK && (idx_q == c_idx_last) && (w_nibble == 4'd0))
                 || (blink_ph_q && w_field_blink);
        w_seg_on = w_blank ? 7'h00 : ~seg_code_low(w_nibble);
        w_dp_on  = bus.colon_on && ((idx_q == 3'd2) || (idx_q == 3'd4)) && !w_blank;
        w_an_on  = 6'd1 << idx_q;

        seg_d = SEG_ACT_LOW ? ~w_seg_on : w_seg_on;
        dp_d  = SEG_ACT_LOW ? ~w_dp_on  : w_dp_on;
        an_d  = AN_ACT_LOW  ? ~w_an_on  : w_an_on;
    end

    // State and output registers; reset aborts the frame and blanks the display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            snap_hour_q <= 8'h00;
            snap_min_q  <= 8'h00;
            snap_sec_q  <= 8'h00;
            seg_q       <= c_seg_off;
            dp_q        <= c_dp_off;
            an_q        <= c_an_off;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            snap_hour_q <= snap_hour_d;
            snap_min_q  <= snap_min_d;
            snap_sec_q  <= snap_sec_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;

endmodule
`default_nettype wire
